// File: rtl/stack_xfer_seq_if.sv
// Byte-wide memory bus between the stack sequencer (master) and the memory
// interface (slave).
//   mem_req   : transaction request, held until mem_ack
//   mem_we    : 1=write, 0=read; valid while mem_req
//   mem_addr  : byte address (the current stack pointer during a transfer)
//   mem_wdata : write byte
//   mem_rdata : read byte, valid in the cycle mem_ack=1
//   mem_ack   : completes the transfer; may arrive in the same cycle as mem_req
interface stack_xfer_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stack_xfer_seq.sv
// Stack transfer sequencer: runs the two-byte memory traffic of a 16-bit PUSH
// or POP at the current stack pointer and pulses sp_incr/sp_decr back to the
// stack-pointer owner. SP itself lives outside this block.
//   clock, reset        : clock and synchronous active-high reset
//   push_req, pop_req   : start requests, sampled only in IDLE (push wins)
//   push_data           : word to push, captured on accept
//   sp                  : current stack pointer from the SP owner
//   sp_incr, sp_decr    : one-cycle SP adjust pulses
//   pop_data            : last popped word, updated byte-wise per ack
//   busy, done, error   : status; done/error are one-cycle pulses
//   bus                 : memory bus master
//
// state   | meaning
// IDLE    | waiting for push_req / pop_req
// P_DEC1  | SP-1 before the high byte
// P_WR_HI | write data[15:8] at SP, wait for ack
// P_DEC2  | SP-1 before the low byte
// P_WR_LO | write data[7:0] at SP, wait for ack
// R_RD_LO | read low byte at SP, wait for ack
// R_INC1  | SP+1 after the low byte
// R_RD_HI | read high byte at SP, wait for ack
// R_INC2  | SP+1 after the high byte
// FIN     | done pulse, back to IDLE
module stack_xfer_seq #(
  parameter int TIMEOUT = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push_req,
  input  logic               pop_req,
  input  logic [15:0]        push_data,
  input  logic [15:0]        sp,
  output logic               sp_incr,
  output logic               sp_decr,
  output logic [15:0]        pop_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  stack_xfer_seq_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, P_DEC1, P_WR_HI, P_DEC2, P_WR_LO,
    R_RD_LO, R_INC1, R_RD_HI, R_INC2, FIN
  } state_t;

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t         state;
  state_t         nxt;
  logic [15:0]    data_q;
  logic [WDW-1:0] wd_cnt;
  logic           xfer;
  logic           abort;

  assign xfer  = state inside {P_WR_HI, P_WR_LO, R_RD_LO, R_RD_HI};
  // wd_cnt counts wait cycles already spent; this cycle is the TIMEOUT-th
  assign abort = (TIMEOUT > 0) && xfer && !bus.mem_ack &&
                 (wd_cnt == WDW'(TIMEOUT - 1));

  // mem_req is only ever high in a transfer state, so it doubles as the
  // address enable
  assign bus.mem_addr = bus.mem_req ? sp : 16'h0000;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (push_req)     nxt = P_DEC1;
        else if (pop_req) nxt = R_RD_LO;
      end
      P_DEC1:  nxt = P_WR_HI;
      P_WR_HI: if (bus.mem_ack) nxt = P_DEC2;
      P_DEC2:  nxt = P_WR_LO;
      P_WR_LO: if (bus.mem_ack) nxt = FIN;
      R_RD_LO: if (bus.mem_ack) nxt = R_INC1;
      R_INC1:  nxt = R_RD_HI;
      R_RD_HI: if (bus.mem_ack) nxt = R_INC2;
      R_INC2:  nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      data_q        <= '0;
      wd_cnt        <= '0;
      pop_data      <= '0;
      sp_incr       <= 1'b0;
      sp_decr       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && push_req) data_q <= push_data;
      if (bus.mem_ack && state == R_RD_LO) pop_data[7:0]  <= bus.mem_rdata;
      if (bus.mem_ack && state == R_RD_HI) pop_data[15:8] <= bus.mem_rdata;
      // cleared outside transfers, so each transfer state starts at zero
      wd_cnt <= (xfer && !bus.mem_ack && !abort) ? wd_cnt + 1'b1 : '0;

      sp_decr     <= nxt inside {P_DEC1, P_DEC2};
      sp_incr     <= nxt inside {R_INC1, R_INC2};
      bus.mem_req <= nxt inside {P_WR_HI, P_WR_LO, R_RD_LO, R_RD_HI};
      bus.mem_we  <= nxt inside {P_WR_HI, P_WR_LO};
      if (nxt == P_WR_HI)      bus.mem_wdata <= data_q[15:8];
      else if (nxt == P_WR_LO) bus.mem_wdata <= data_q[7:0];
      else                     bus.mem_wdata <= '0;
      busy  <= (nxt != IDLE);
      done  <= (nxt == FIN);
      error <= abort;
    end
  end

endmodule

// File: tb/tb_stack_xfer_seq.sv
module tb_stack_xfer_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        push_req, pop_req;
  logic [15:0] push_data, sp;
  logic        sp_incr, sp_decr, busy, done, error;
  logic [15:0] pop_data;

  logic        wd_push_req, wd_pop_req;
  logic [15:0] wd_push_data, wd_sp;
  logic        wd_sp_incr, wd_sp_decr, wd_busy, wd_done, wd_error;
  logic [15:0] wd_pop_data;

  stack_xfer_seq_if bus ();
  stack_xfer_seq_if bus_wd ();

  stack_xfer_seq #(.TIMEOUT(0)) u_dut (
    .clock(clock), .reset(reset), .push_req(push_req), .pop_req(pop_req),
    .push_data(push_data), .sp(sp), .sp_incr(sp_incr), .sp_decr(sp_decr),
    .pop_data(pop_data), .busy(busy), .done(done), .error(error), .bus(bus)
  );

  stack_xfer_seq #(.TIMEOUT(4)) u_wd (
    .clock(clock), .reset(reset), .push_req(wd_push_req), .pop_req(wd_pop_req),
    .push_data(wd_push_data), .sp(wd_sp), .sp_incr(wd_sp_incr), .sp_decr(wd_sp_decr),
    .pop_data(wd_pop_data), .busy(wd_busy), .done(wd_done), .error(wd_error), .bus(bus_wd)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [15:0] rd_addr[$];
  logic        busy_log [0:63];
  int          cyc_n, done_cyc, n_done, n_err, n_decr, n_incr;
  int          wait_cfg, wait_left;
  logic [15:0] pd_at_done;
  logic        prev_req, prev_ack, prev_we;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and respond at negedge, move bench SP after posedge.
  task automatic tick();
    logic dec, inc;
    @(negedge clock);
    check("pulse_excl", {30'd0, sp_incr && sp_decr, (sp_incr || sp_decr) && bus.mem_req}, 32'd0);
    if (bus.mem_req) check("addr_eq_sp", {16'd0, bus.mem_addr}, {16'd0, sp});
    if (bus.mem_req && prev_req && !prev_ack)
      check("hold_bus", {7'd0, bus.mem_we, bus.mem_wdata, bus.mem_addr},
                        {7'd0, prev_we, prev_wd, prev_addr});
    if (bus.mem_req) begin
      if (wait_left == 0) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
        end else begin
          bus.mem_rdata = mem[bus.mem_addr];
          rd_addr.push_back(bus.mem_addr);
        end
        wait_left = wait_cfg;
      end else begin
        bus.mem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      bus.mem_ack = 1'b0;
    end
    if (cyc_n < 64) busy_log[cyc_n] = busy;
    if (done) begin
      if (done_cyc < 0) done_cyc = cyc_n;
      pd_at_done = pop_data;
      n_done++;
    end
    if (error) n_err++;
    dec = sp_decr;
    inc = sp_incr;
    if (dec) n_decr++;
    if (inc) n_incr++;
    prev_req  = bus.mem_req;
    prev_ack  = bus.mem_ack;
    prev_we   = bus.mem_we;
    prev_addr = bus.mem_addr;
    prev_wd   = bus.mem_wdata;
    @(posedge clock);
    #1;
    if (dec) sp = sp - 16'd1;
    if (inc) sp = sp + 16'd1;
    cyc_n++;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    cyc_n = 0; done_cyc = -1; n_done = 0; n_err = 0; n_decr = 0; n_incr = 0;
    wait_left = wait_cfg;
    for (int i = 0; i < 64; i++) busy_log[i] = 1'bx;
  endtask

  // Accept in cycle 0, hold pop_req in cycles pop_lo..pop_hi, run to done + 1.
  task automatic run_op(input logic pu, input logic po, input logic [15:0] data,
                        input int pop_lo, input int pop_hi);
    clear_logs();
    push_req = pu; pop_req = po; push_data = data;
    tick();
    push_req = 1'b0;
    while (done_cyc < 0 && cyc_n < 40) begin
      pop_req = (cyc_n >= pop_lo && cyc_n <= pop_hi);
      tick();
    end
    pop_req = 1'b0;
    tick();
  endtask

  initial begin
    int wd_err_cyc, wd_req_n, wd_done_n, wd_err_n;
    logic wd_busy5;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h5A;
    reset = 1'b1; push_req = 1'b0; pop_req = 1'b0; push_data = '0; sp = 16'hFFFE;
    wd_push_req = 1'b0; wd_pop_req = 1'b0; wd_push_data = '0; wd_sp = 16'h1000;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus_wd.mem_ack = 1'b0; bus_wd.mem_rdata = '0;
    prev_req = 0; prev_ack = 0; prev_we = 0; prev_addr = '0; prev_wd = '0;
    wait_cfg = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_status", {29'd0, busy, done, error}, 32'd0);
    check("rst_bus", {14'd0, bus.mem_req, bus.mem_we, bus.mem_addr}, 32'd0);
    check("rst_pop_data", {16'd0, pop_data}, 32'd0);
    check("rst_sp_pulses", {30'd0, sp_incr, sp_decr}, 32'd0);
    @(posedge clock); #1;

    // push 0xBEEF at SP=0xFFFE, zero wait
    run_op(1'b1, 1'b0, 16'hBEEF, 99, 99);
    check("push_done_cyc", done_cyc, 5);
    check("push_n_wr", wr_addr.size(), 2);
    check("push_wr0", {wr_addr[0], 8'd0, wr_data[0]}, {16'hFFFD, 8'd0, 8'hBE});
    check("push_wr1", {wr_addr[1], 8'd0, wr_data[1]}, {16'hFFFC, 8'd0, 8'hEF});
    check("push_n_decr", n_decr, 2);
    check("push_sp", {16'd0, sp}, 32'h0000FFFC);
    check("push_busy_c6", {31'd0, busy_log[6]}, 32'd0);

    // pop back, zero wait
    run_op(1'b0, 1'b1, 16'h0000, 99, 99);
    check("pop_done_cyc", done_cyc, 5);
    check("pop_n_rd", rd_addr.size(), 2);
    check("pop_rd0", {16'd0, rd_addr[0]}, 32'h0000FFFC);
    check("pop_rd1", {16'd0, rd_addr[1]}, 32'h0000FFFD);
    check("pop_data", {16'd0, pd_at_done}, 32'h0000BEEF);
    check("pop_sp", {16'd0, sp}, 32'h0000FFFE);

    // push 0x1234 with 3 wait cycles per byte
    wait_cfg = 3;
    run_op(1'b1, 1'b0, 16'h1234, 99, 99);
    check("wait_done_cyc", done_cyc, 11);
    check("wait_n_decr", n_decr, 2);
    check("wait_wr0", {wr_addr[0], 8'd0, wr_data[0]}, {16'hFFFD, 8'd0, 8'h12});
    check("wait_wr1", {wr_addr[1], 8'd0, wr_data[1]}, {16'hFFFC, 8'd0, 8'h34});
    check("wait_busy_c12", {31'd0, busy_log[12]}, 32'd0);
    wait_cfg = 0;

    // wrap-around push from 0x0000, then pop across 0xFFFF -> 0x0000
    sp = 16'h0000;
    run_op(1'b1, 1'b0, 16'h1234, 99, 99);
    check("wrap_wr0", {wr_addr[0], 8'd0, wr_data[0]}, {16'hFFFF, 8'd0, 8'h12});
    check("wrap_wr1", {wr_addr[1], 8'd0, wr_data[1]}, {16'hFFFE, 8'd0, 8'h34});
    check("wrap_push_sp", {16'd0, sp}, 32'h0000FFFE);
    sp = 16'hFFFF;
    run_op(1'b0, 1'b1, 16'h0000, 99, 99);
    check("wrap_rd0", {16'd0, rd_addr[0]}, 32'h0000FFFF);
    check("wrap_rd1", {16'd0, rd_addr[1]}, 32'h00000000);
    check("wrap_pop_data", {16'd0, pd_at_done}, 32'h00005A12);
    check("wrap_pop_sp", {16'd0, sp}, 32'h00000001);

    // push and pop together, then pop_req held while busy through FIN
    sp = 16'h2000;
    run_op(1'b1, 1'b1, 16'hA5C3, 2, 5);
    check("arb_n_wr", wr_addr.size(), 2);
    check("arb_n_rd", rd_addr.size(), 0);
    check("arb_n_incr", n_incr, 0);
    check("arb_sp", {16'd0, sp}, 32'h00001FFE);
    check("arb_busy_c6", {31'd0, busy_log[6]}, 32'd0);
    repeat (3) tick();
    check("arb_no_second_op", {rd_addr.size(), 31'd0, busy}, 64'd0);

    // reset while waiting in P_WR_LO
    wait_cfg = 50;
    clear_logs();
    wait_left = 0;
    push_req = 1'b1; push_data = 16'h7777;
    tick();
    push_req = 1'b0;
    repeat (4) tick();
    check("rst_mid_in_wr_lo", {30'd0, bus.mem_req, bus.mem_we}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_req_busy", {30'd0, bus.mem_req, busy}, 32'd0);
    repeat (2) tick();
    check("rst_mid_no_done", {n_done, n_err}, 64'd0);
    check("rst_mid_sp", {16'd0, sp}, 32'h00001FFC);
    wait_cfg = 0;

    // watchdog: TIMEOUT=4 instance, ack never arrives
    wd_err_cyc = -1; wd_req_n = 0; wd_done_n = 0; wd_err_n = 0; wd_busy5 = 1'bx;
    wd_pop_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus_wd.mem_req) wd_req_n++;
      if (wd_done) wd_done_n++;
      if (wd_error) begin
        wd_err_n++;
        if (wd_err_cyc < 0) wd_err_cyc = c;
      end
      if (c == 5) wd_busy5 = wd_busy;
      @(posedge clock); #1;
      wd_pop_req = 1'b0;
    end
    check("wd_err_cyc", wd_err_cyc, 5);
    check("wd_req_cycles", wd_req_n, 4);
    check("wd_err_pulses", wd_err_n, 1);
    check("wd_no_done", wd_done_n, 0);
    check("wd_idle_after", {30'd0, wd_busy5, bus_wd.mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
